// File: rtl/free_list.sv
`default_nettype none
// ---------------------------------------------------------------------------
// free_list : circular FIFO of free physical registers, 3-wide alloc/refill
// Rev 1.0
// ---------------------------------------------------------------------------
module free_list #(
   parameter int PR_W    = 6,
   parameter int PR_NUM  = 64,
   parameter int FL_SIZE = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          dispatch_req,
   output logic [3*PR_W-1:0]   new_pr,
   output logic                fl_stall,
   output logic [1:0]          avail_num,
   input  logic [2:0]          retire_valid,
   input  logic [3*PR_W-1:0]   retire_told,
   input  logic                BPRecoverEN
);

   // FL_SIZE is a power of two, so pointer sums wrap naturally at PTR_W bits.
   localparam int PTR_W = $clog2(FL_SIZE);
   localparam int CNT_W = $clog2(FL_SIZE + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FL_SIZE);

   logic [PR_W-1:0]  r_entry [FL_SIZE];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [1:0]       w_nreq;
   logic [1:0]       w_nret;
   logic [1:0]       w_npop;
   logic             w_stall;
   logic [PTR_W-1:0] w_rd_off [3];
   logic [PTR_W-1:0] w_wr_off [3];
   logic [PTR_W-1:0] w_tail_next;

   assign w_nreq = {1'b0, dispatch_req[0]} + {1'b0, dispatch_req[1]} + {1'b0, dispatch_req[2]};
   assign w_nret = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]} + {1'b0, retire_valid[2]};

   assign w_stall   = CNT_W'(w_nreq) > r_count;
   assign fl_stall  = w_stall;
   assign avail_num = (r_count >= CNT_W'(3)) ? 2'd3 : r_count[1:0];
   assign w_npop    = (w_stall || BPRecoverEN) ? 2'd0 : w_nreq;

   // Slot 2 is oldest: it takes the first entry, younger slots follow compacted.
   assign w_rd_off[2] = '0;
   assign w_rd_off[1] = PTR_W'(dispatch_req[2]);
   assign w_rd_off[0] = PTR_W'(dispatch_req[2]) + PTR_W'(dispatch_req[1]);
   assign w_wr_off[2] = '0;
   assign w_wr_off[1] = PTR_W'(retire_valid[2]);
   assign w_wr_off[0] = PTR_W'(retire_valid[2]) + PTR_W'(retire_valid[1]);

   assign w_tail_next = r_tail + PTR_W'(w_nret);

   generate
      for (genvar s = 0; s < 3; s++) begin : g_slot
         assign new_pr[s*PR_W +: PR_W] = (dispatch_req[s] && !w_stall) ?
                                         r_entry[r_head + w_rd_off[s]] : '0;
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FL_SIZE; i++) begin
            r_entry[i] <= PR_W'(PR_NUM - FL_SIZE + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= C_FULL;
      end else begin
         for (int s = 0; s < 3; s++) begin
            if (retire_valid[s]) begin
               r_entry[r_tail + w_wr_off[s]] <= retire_told[s*PR_W +: PR_W];
            end
         end
         r_tail <= w_tail_next;
         // Committed head always equals tail, so recovery snaps head onto it.
         if (BPRecoverEN) begin
            r_head  <= w_tail_next;
            r_count <= C_FULL;
         end else begin
            r_head  <= r_head + PTR_W'(w_npop);
            r_count <= r_count - CNT_W'(w_npop) + CNT_W'(w_nret);
         end
      end
   end

endmodule
`default_nettype wire
